// File: rtl/ibex_rvfi_trace_buffer_pkg.sv
// Shared types for the RVFI retirement trace buffer: capture modes, FSM states
// and the fixed-width parts of a trace record.
package ibex_rvfi_trace_buffer_pkg;

    typedef enum logic [1:0] {
        TRACE_OFF       = 2'd0,
        TRACE_CONT      = 2'd1,
        TRACE_STOP_FULL = 2'd2,
        TRACE_TRIGGER   = 2'd3
    } trace_mode_e;

    typedef enum logic [1:0] {
        TRACE_IDLE    = 2'd0,
        TRACE_CAPTURE = 2'd1,
        TRACE_POST    = 2'd2,
        TRACE_FROZEN  = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] rd_wdata;
        logic [4:0]  rd_addr;
        logic [1:0]  mode;
        logic        trap;
        logic        intr;
    } trace_core_t;

    typedef struct packed {
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
    } trace_mem_t;

    localparam int unsigned TRACE_DROP_W = 16;
    localparam int unsigned TRACE_CORE_W = $bits(trace_core_t);
    localparam int unsigned TRACE_MEM_W  = $bits(trace_mem_t);

    // Record layout, LSB first: timestamp, core fields, then optional memory fields.
    function automatic int unsigned trace_rec_width(input int unsigned ts_w, input bit store_mem);
        return ts_w + TRACE_CORE_W + (store_mem ? TRACE_MEM_W : 0);
    endfunction

endpackage

// File: rtl/ibex_rvfi_trace_buffer_ring.sv
// Ring storage with first-word fall-through read port; full-buffer pushes either
// overwrite the oldest entry or are discarded, and either way are reported as drops.
module ibex_rvfi_trace_buffer_ring #(
    parameter  int unsigned Depth = 64,
    parameter  int unsigned Width = 32,
    localparam int unsigned AW    = $clog2(Depth),
    localparam int unsigned CW    = $clog2(Depth) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             overwrite_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             drop_o
);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [Width-1:0] rdata_reg;
    logic             full, do_pop, do_write, rd_adv;

    always_comb begin
        full        = (count_reg == CW'(Depth));
        do_pop      = pop_i & (count_reg != '0);
        drop_o      = push_i & full & ~do_pop;
        do_write    = push_i & ~flush_i & (~full | do_pop | overwrite_i);
        rd_adv      = do_pop | (drop_o & overwrite_i);
        wr_ptr_next = do_write ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
        rd_ptr_next = rd_adv ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        count_next  = count_reg;
        if (do_write && !rd_adv) begin
            count_next = count_reg + CW'(1);
        end else if (!do_write && do_pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[wr_ptr_reg] <= wdata_i;
        end
    end

    // Registered read addressed by the next read pointer; a write landing on that
    // address this cycle is forwarded so a fresh record appears one cycle after push.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rdata_reg <= '0;
        end else if (do_write && (wr_ptr_reg == rd_ptr_next)) begin
            rdata_reg <= wdata_i;
        end else begin
            rdata_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign rdata_o = rdata_reg;
    assign count_o = count_reg;

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// On-chip RVFI retirement trace buffer: timestamps retirements, captures them in a
// ring under one of four modes with PC/trap trigger, and unloads oldest-first.
module ibex_rvfi_trace_buffer
    import ibex_rvfi_trace_buffer_pkg::*;
#(
    parameter  int unsigned Depth    = 64,
    parameter  bit          StoreMem = 1'b1,
    parameter  int unsigned TsWidth  = 32,
    localparam int unsigned CW       = $clog2(Depth) + 1,
    localparam int unsigned RecW     = trace_rec_width(TsWidth, StoreMem)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              cfg_mode_i,
    input  logic                    arm_i,
    input  logic                    clear_i,
    input  logic [CW-1:0]           post_trig_i,
    input  logic                    trig_pc_en_i,
    input  logic [31:0]             trig_pc_i,
    input  logic                    trig_on_trap_i,
    input  logic                    rvfi_valid,
    input  logic [31:0]             rvfi_insn,
    input  logic [31:0]             rvfi_pc_rdata,
    input  logic [31:0]             rvfi_rd_wdata,
    input  logic [31:0]             rvfi_mem_addr,
    input  logic [4:0]              rvfi_rd_addr,
    input  logic [1:0]              rvfi_mode,
    input  logic                    rvfi_trap,
    input  logic                    rvfi_intr,
    input  logic [3:0]              rvfi_mem_rmask,
    input  logic [3:0]              rvfi_mem_wmask,
    output logic                    rec_valid_o,
    input  logic                    rec_ready_i,
    output logic [RecW-1:0]         rec_o,
    output logic [CW-1:0]           count_o,
    output logic [1:0]              state_o,
    output logic                    triggered_o,
    output logic                    overflow_o,
    output logic [TRACE_DROP_W-1:0] drop_cnt_o
);

    trace_state_e            state_reg, state_next;
    trace_mode_e             mode_reg, mode_next;
    logic [CW-1:0]           post_trig_reg, post_trig_next;
    logic [CW-1:0]           post_cnt_reg, post_cnt_next;
    logic                    triggered_reg, triggered_next;
    logic                    overflow_reg, overflow_next;
    logic [TRACE_DROP_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic [TsWidth-1:0]      ts_reg;

    logic            push, trig_hit, ring_drop;
    logic [CW-1:0]   ring_count;
    logic [RecW-1:0] rec_wdata;
    trace_core_t     core_fields;

    assign core_fields = '{insn: rvfi_insn, pc: rvfi_pc_rdata, rd_wdata: rvfi_rd_wdata,
                           rd_addr: rvfi_rd_addr, mode: rvfi_mode, trap: rvfi_trap,
                           intr: rvfi_intr};

    generate
        if (StoreMem) begin : g_mem
            trace_mem_t mem_fields;
            assign mem_fields = '{mem_addr: rvfi_mem_addr, mem_rmask: rvfi_mem_rmask,
                                  mem_wmask: rvfi_mem_wmask};
            assign rec_wdata  = {mem_fields, core_fields, ts_reg};
        end else begin : g_no_mem
            assign rec_wdata = {core_fields, ts_reg};
        end
    endgenerate

    assign push     = rvfi_valid & ~clear_i &
                      ((state_reg == TRACE_CAPTURE) | (state_reg == TRACE_POST));
    assign trig_hit = rvfi_valid & ((trig_pc_en_i & (rvfi_pc_rdata == trig_pc_i)) |
                                    (trig_on_trap_i & (rvfi_trap | rvfi_intr)));

    ibex_rvfi_trace_buffer_ring #(
        .Depth (Depth),
        .Width (RecW)
    ) u_ring (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (clear_i),
        .push_i      (push),
        .overwrite_i (mode_reg != TRACE_STOP_FULL),
        .wdata_i     (rec_wdata),
        .pop_i       (rec_ready_i),
        .rdata_o     (rec_o),
        .count_o     (ring_count),
        .drop_o      (ring_drop)
    );

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        post_trig_next = post_trig_reg;
        post_cnt_next  = post_cnt_reg;
        triggered_next = triggered_reg;
        overflow_next  = overflow_reg;
        drop_cnt_next  = drop_cnt_reg;
        if (clear_i) begin
            state_next     = TRACE_IDLE;
            post_cnt_next  = '0;
            triggered_next = 1'b0;
            overflow_next  = 1'b0;
            drop_cnt_next  = '0;
        end else begin
            // Pre-trigger wrap is the normal operating point in TRIGGER mode, so it
            // counts drops but does not raise the overflow flag.
            if (ring_drop) begin
                if (drop_cnt_reg != '1) drop_cnt_next = drop_cnt_reg + 1'b1;
                if (mode_reg != TRACE_TRIGGER) overflow_next = 1'b1;
            end
            unique case (state_reg)
                TRACE_IDLE, TRACE_FROZEN: begin
                    if (arm_i && (cfg_mode_i != TRACE_OFF)) begin
                        state_next     = TRACE_CAPTURE;
                        mode_next      = trace_mode_e'(cfg_mode_i);
                        post_trig_next = post_trig_i;
                        post_cnt_next  = '0;
                        triggered_next = 1'b0;
                    end
                end
                TRACE_CAPTURE: begin
                    if ((mode_reg == TRACE_STOP_FULL) && ring_drop) begin
                        state_next = TRACE_FROZEN;
                    end else if ((mode_reg == TRACE_TRIGGER) && trig_hit && !triggered_reg) begin
                        triggered_next = 1'b1;
                        post_cnt_next  = '0;
                        state_next     = (post_trig_reg == '0) ? TRACE_FROZEN : TRACE_POST;
                    end
                end
                TRACE_POST: begin
                    if (push) begin
                        post_cnt_next = post_cnt_reg + CW'(1);
                        if (post_cnt_reg + CW'(1) == post_trig_reg) state_next = TRACE_FROZEN;
                    end
                end
                default: state_next = TRACE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= TRACE_IDLE;
            mode_reg      <= TRACE_OFF;
            post_trig_reg <= '0;
            post_cnt_reg  <= '0;
            triggered_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            drop_cnt_reg  <= '0;
            ts_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            post_trig_reg <= post_trig_next;
            post_cnt_reg  <= post_cnt_next;
            triggered_reg <= triggered_next;
            overflow_reg  <= overflow_next;
            drop_cnt_reg  <= drop_cnt_next;
            ts_reg        <= ts_reg + TsWidth'(1);
        end
    end

    assign rec_valid_o = (ring_count != '0);
    assign count_o     = ring_count;
    assign state_o     = state_reg;
    assign triggered_o = triggered_reg;
    assign overflow_o  = overflow_reg;
    assign drop_cnt_o  = drop_cnt_reg;

endmodule
